arm_mem_arbiter: RTL
====================

Name: arm_mem_arbiter

Overview:
- Shares one unified memory port between instruction fetch and data load/store for the multi-cycle ARM core.
- Arbitrates between the two requesters, issues one memory transaction at a time and waits for a variable-latency acknowledge.
- Generates byte enables and byte lane steering for LDRB/STRB and returns read data to the winning requester.
- Sits between the fetch/control logic and the memory model; the control unit stalls the PC and register writes while a requester awaits its valid.

Parameters:
- STARVE_LIMIT, 4, consecutive data wins after which fetch is forced to win (used only with the optional feature).
- TIMEOUT, 255, max cycles in a BUSY state waiting for mem_ack before mem_err is raised (8-bit counter).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_valid.
- if_addr  in  32  fetch byte address; bits [1:0] ignored.
- if_gnt  out  1  1-cycle pulse: fetch accepted.
- if_valid  out  1  1-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched word.
- d_req  in  1  data request; held high until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_byte  in  1  1 = byte access, 0 = word access.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data; byte stores use [7:0].
- d_gnt  out  1  1-cycle pulse: data accepted.
- d_valid  out  1  1-cycle pulse: load data returned, or store complete.
- d_rdata  out  32  load data; byte loads are zero-extended.
- mem_req  out  1  memory transaction active.
- mem_addr  out  30  word address.
- mem_we  out  4  byte write enables; 0 = read.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  transaction done.
- busy  out  1  state is not IDLE.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset: state = IDLE. All outputs are 0; counters are 0.
- Reset is asynchronous and may assert mid-transaction. It aborts the transaction, drops mem_req immediately and suppresses any valid.
- State machine:
  - IDLE -> D_BUSY when d_req = 1.
  - IDLE -> IF_BUSY when d_req = 0 and if_req = 1.
  - IF_BUSY or D_BUSY -> RESP on mem_ack.
  - RESP -> IDLE after one cycle.
- Arbitration: data has priority over fetch when both requests are high in the IDLE cycle.
- Grant:
  - The matching gnt pulses in the IDLE cycle that takes the transition.
  - Address, we, byte and wdata are registered that cycle.
  - mem_* is driven from the registered copies from the next cycle until mem_ack inclusive.
- mem_addr = latched addr[31:2].
- Word store: mem_we = 4'b1111, mem_wdata = wdata.
- Byte store: mem_we = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}.
- Loads and fetches: mem_we = 0.
- Capture: mem_rdata is registered on the mem_ack cycle.
  - Word load: d_rdata = the word.
  - Byte load: d_rdata = {24'b0, byte lane addr[1:0]}.
  - Fetch: if_rdata = the word; addr[1:0] is ignored.
- Response: in RESP the owning valid pulses for 1 cycle. rdata holds its value until the next capture.
- Minimum latency: req at cycle 0 (IDLE), mem_req at 1, ack at 1, valid at 2, IDLE at 3.
- mem_ack while IDLE or RESP is ignored.
- Requests are sampled only in IDLE; a request raised during BUSY or RESP waits.
- A requester that drops req before valid is a protocol violation. The transaction still completes and valid still pulses.
- Timeout:
  - The wait counter resets on entering a BUSY state and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, mem_err is set (sticky until reset). State goes to RESP with rdata = 32'hDEAD_BEEF, and valid pulses.

Optional Feature:
- Macro ARM_MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter counts consecutive data grants made while if_req = 1.
  - When the count reaches STARVE_LIMIT, the next IDLE arbitration grants fetch even if d_req = 1.
  - The counter clears on any fetch grant.
- Undefined: strict data priority; the counter is not built.

Test Plan:
- Fetch, if_addr = 0x100, mem_ack 3 cycles after mem_req -> mem_addr = 0x40, mem_we = 0; if_valid 1 cycle after ack; if_rdata = mem_rdata = 0xE3A01005.
- Simultaneous if_req and d_req (load, d_addr = 0x2000) -> d_gnt first, mem_addr = 0x800. Fetch is granted in the IDLE cycle after d_valid.
- STRB d_addr = 0x2003, d_wdata = 0x1234_56AB -> mem_we = 4'b1000, mem_wdata = 0xABABABAB, d_valid after ack.
- LDRB d_addr = 0x2001, mem_rdata = 0x11223344 -> d_rdata = 0x00000033. LDR word at the same address -> d_rdata = 0x11223344.
- No mem_ack for 255 BUSY cycles -> mem_err = 1, valid pulses with rdata = 0xDEADBEEF. Assert rst_b low mid-BUSY on another transaction -> mem_req = 0 immediately, no valid, mem_err = 0.
- With ARM_MEM_ARB_STARVE_GUARD_EN, d_req and if_req held high continuously -> data granted 4 times, then fetch. Without the macro, fetch is never granted while d_req = 1.

Source files
------------

// File: rtl/arm_mem_arbiter.sv
// Unified memory port arbiter for instruction fetch and data load/store.
// Optional fetch starvation guard: define ARM_MEM_ARB_STARVE_GUARD_EN.
module arm_mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_byte,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        mem_err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must fit the 3-bit starvation counter (1..7)");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("TIMEOUT must fit the 8-bit wait counter (1..255)");
  end

  // Handshake: a requester raises req and holds it until its valid pulses;
  // gnt pulses in the accepting IDLE cycle, valid pulses once in RESP.
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic        own_d;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we, lat_byte;
  logic [7:0]  wait_cnt;
  logic        in_busy, timeout_hit;
  logic        grant_d, grant_if;
  logic        starve_force;
  logic [7:0]  lane;

`ifdef ARM_MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign starve_force = (starve_cnt >= 3'(STARVE_LIMIT)) && if_req;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      starve_cnt <= '0;
    else if (grant_if)
      starve_cnt <= '0;
    else if (grant_d && if_req && starve_cnt != 3'd7)
      starve_cnt <= starve_cnt + 3'd1;
  end
`else
  assign starve_force = 1'b0;
`endif

  assign in_busy     = (state == IF_BUSY) || (state == D_BUSY);
  assign timeout_hit = in_busy && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));
  // Reset gating keeps grants quiet while rst_b is held low.
  assign grant_d     = rst_b && (state == IDLE) && d_req && !starve_force;
  assign grant_if    = rst_b && (state == IDLE) && if_req && !grant_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)       state_nxt = D_BUSY;
        else if (grant_if) state_nxt = IF_BUSY;
      end
      IF_BUSY, D_BUSY: begin
        if (mem_ack || timeout_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (lat_addr[1:0])
      2'd0:    lane = mem_rdata[7:0];
      2'd1:    lane = mem_rdata[15:8];
      2'd2:    lane = mem_rdata[23:16];
      default: lane = mem_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      own_d     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      lat_byte  <= 1'b0;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d) begin
        own_d     <= 1'b1;
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
        lat_we    <= d_we;
        lat_byte  <= d_byte;
        wait_cnt  <= '0;
      end else if (grant_if) begin
        own_d     <= 1'b0;
        lat_addr  <= if_addr;
        lat_wdata <= '0;
        lat_we    <= 1'b0;
        lat_byte  <= 1'b0;
        wait_cnt  <= '0;
      end
      if (in_busy && mem_ack) begin
        if (state == IF_BUSY)
          if_rdata <= mem_rdata;
        else if (!lat_we)
          d_rdata <= lat_byte ? {24'b0, lane} : mem_rdata;
      end else if (timeout_hit) begin
        mem_err <= 1'b1;
        if (state == IF_BUSY) if_rdata <= 32'hDEAD_BEEF;
        else                  d_rdata  <= 32'hDEAD_BEEF;
      end else if (in_busy) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_req   = in_busy;
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    if_valid  = (state == RESP) && !own_d;
    d_valid   = (state == RESP) && own_d;
    mem_addr  = '0;
    mem_we    = '0;
    mem_wdata = '0;
    if (in_busy) begin
      mem_addr = lat_addr[31:2];
      if (lat_we) begin
        mem_we    = lat_byte ? (4'b0001 << lat_addr[1:0]) : 4'b1111;
        mem_wdata = lat_byte ? {4{lat_wdata[7:0]}} : lat_wdata;
      end
    end
  end

endmodule
